serial_result_collector: RTL and testbench
==========================================

SERIAL_RESULT_COLLECTOR -- requirements
Module: serial_result_collector

Interface
REQ-001 Parameter: WIDTH, default 8, number of serial result bits per operation (legal range 2..16).
REQ-002 Port: clock  input  1  single rising-edge clock for all state.
REQ-003 Port: resetn  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  begin a new collection; discards any partial word.
REQ-005 Port: bit_valid  input  1  sum_bit/carry_bit valid this cycle (serial datapath enable).
REQ-006 Port: sum_bit  input  1  serial sum bit, LSB first.
REQ-007 Port: carry_bit  input  1  current carry from serial adder; sampled with the final bit.
REQ-008 Port: result_ready  input  1  consumer accepts result this cycle.
REQ-009 Port: result  output  WIDTH  assembled parallel word.
REQ-010 Port: carry_out  output  1  carry sampled with the WIDTH-th bit.
REQ-011 Port: result_valid  output  1  result/carry_out/parity valid, held until accepted.
REQ-012 Port: busy  output  1  high in COLLECT.
REQ-013 Port: overrun  output  1  sticky flag: bit_valid seen while in HOLD.
REQ-014 Port: parity  output  1  even-parity bit of result (see Configuration).

Function
REQ-015 States SHALL be IDLE, COLLECT, HOLD; only these three encodings reachable.
REQ-016 IDLE: start=1 -> COLLECT, bit counter cleared to 0, shift register cleared; else stay.
REQ-017 COLLECT: each cycle with bit_valid=1 shifts sum_bit into result MSB (shift right) and increments counter; bit_valid=0 holds everything (gaps allowed).
REQ-018 COLLECT: when accepted bit is the WIDTH-th (counter==WIDTH-1 and bit_valid=1) -> HOLD next cycle, carry_out captured from carry_bit that same cycle.
REQ-019 After WIDTH accepted bits, result[0] SHALL equal the first bit received (LSB-first order preserved).
REQ-020 result_valid SHALL assert the cycle after the WIDTH-th bit is accepted (latency 1) and only in HOLD.
REQ-021 HOLD: result, carry_out, parity stable until result_valid & result_ready; handshake cycle -> IDLE.
REQ-022 start=1 in COLLECT SHALL restart: counter and shift register cleared, stay COLLECT; start has priority over bit_valid that cycle.
REQ-023 start=1 in HOLD SHALL be ignored; consumer must drain first.
REQ-024 bit_valid=1 in HOLD SHALL set overrun, leave result unchanged; overrun clears only on start accepted in IDLE/COLLECT or reset.
REQ-025 bit_valid in IDLE SHALL be ignored and SHALL NOT set overrun.
REQ-026 Counter width SHALL be $clog2(WIDTH+1); no wrap occurs since HOLD is entered at WIDTH bits.

Reset
REQ-027 resetn=0 at a clock edge SHALL force IDLE, counter=0, result=0, carry_out=0, overrun=0; thus result_valid=0, busy=0, parity=0.
REQ-028 Reset mid-COLLECT or mid-HOLD SHALL discard the word with no handshake emitted.

Configuration
REQ-029 Macro SERIAL_PARITY_EN defined: parity = XOR-reduction of result, registered on HOLD entry, valid with result_valid.
REQ-030 Macro undefined: parity tied 0, no parity logic; all other behaviour identical.

Structure
REQ-031 Shared package serial_pkg SHALL hold state typedef (IDLE=2'b00, COLLECT=2'b01, HOLD=2'b11, matching the controller encoding) and default WIDTH constant.
REQ-032 No sub-module; single module with state register, counter, shift register.

Verification
REQ-033 WIDTH=8, start, bits of 0xA5 LSB-first, carry_bit=1 on last, ready=1 -> result=0xA5, carry_out=1, parity=0 (macro on), result_valid 1 cycle after 8th bit, then IDLE.
REQ-034 0x3C with bit_valid gaps of 2 cycles between bits -> result=0x3C, valid only after 8th valid bit.
REQ-035 3 bits sent, start reasserted, then 0x81 -> result=0x81, parity=0; partial bits absent.
REQ-036 HOLD with result_ready=0 for 5 cycles, bit_valid pulsed -> result unchanged, overrun=1, valid held; ready=1 -> IDLE; next start clears overrun.
REQ-037 resetn=0 after 4 bits -> next cycle IDLE, all outputs 0; fresh 0x0F collects correctly, parity=0.
REQ-038 Macro undefined build, 0x01 collected -> parity=0 (tied), result=0x01.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial result collector: controller state
// encoding and the default word width.
package serial_pkg;

  // Controller states; 2'b10 is never entered.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    HOLD    = 2'b11
  } state_e;

  // Default number of serial bits assembled per operation.
  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/serial_result_collector.sv
// Serial result collector: assembles WIDTH LSB-first bits from a serial
// adder into a parallel word. It captures the final carry with the last
// bit and holds the result until a valid/ready handshake completes.
// Optional feature macro: SERIAL_PARITY_EN. When it is defined, an
// even-parity bit of the word is registered on HOLD entry. Otherwise
// parity is tied to 0.
module serial_result_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             sum_bit,
  input  logic             carry_bit,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shift_next;
  logic             carry_q;
  logic             overrun_q;

  // Control strobes from the controller to the datapath.
  logic clear_word;
  logic shift_en;
  logic capture;
  logic set_ovr;
  logic clr_ovr;

  // A new bit enters at the MSB, so the first bit received ends up at bit 0.
  assign shift_next = {sum_bit, shreg_q[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic plus controller outputs and datapath strobes.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned (that would infer a latch).
    state_d      = state_q;
    busy         = 1'b0;
    result_valid = 1'b0;
    clear_word   = 1'b0;
    shift_en     = 1'b0;
    capture      = 1'b0;
    set_ovr      = 1'b0;
    clr_ovr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          clear_word = 1'b1;
          clr_ovr    = 1'b1;
        end
      end
      COLLECT: begin
        busy = 1'b1;
        if (start) begin
          // A restart has priority over a bit arriving in the same cycle.
          clear_word = 1'b1;
          clr_ovr    = 1'b1;
        end else if (bit_valid) begin
          shift_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // start is ignored here; the consumer must drain the word first.
        result_valid = 1'b1;
        set_ovr      = bit_valid;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter, shift register and final-carry capture.
  always_ff @(posedge clock) begin
    // NOTE: the shift register is reset explicitly because result must read
    // 0 out of reset, not merely be ignored until the first word.
    if (!resetn) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      carry_q <= 1'b0;
    end else if (clear_word) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (shift_en) begin
      shreg_q <= shift_next;
      cnt_q   <= cnt_q + CW'(1);
      if (capture) carry_q <= carry_bit;
    end
  end

  // Sticky overrun: set by a bit arriving while a word is held.
  always_ff @(posedge clock) begin
    if (!resetn)      overrun_q <= 1'b0;
    else if (clr_ovr) overrun_q <= 1'b0;
    else if (set_ovr) overrun_q <= 1'b1;
  end

`ifdef SERIAL_PARITY_EN
  logic parity_q;

  // Parity of the complete word, registered as it enters HOLD.
  always_ff @(posedge clock) begin
    if (!resetn)      parity_q <= 1'b0;
    else if (capture) parity_q <= ^shift_next;
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign result    = shreg_q;
  assign carry_out = carry_q;
  assign overrun   = overrun_q;

endmodule : serial_result_collector

// File: tb/tb_serial_result_collector.sv
// Self-checking bench for serial_result_collector. A behavioural model
// collects bits into a queue, forms each word arithmetically, and tracks the
// handshake. A compare process checks the DUT against the model on every
// falling edge. Directed scenarios pin known words; a random phase follows.
module tb_serial_result_collector;

  localparam int W = serial_pkg::DEFAULT_WIDTH;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic         bit_valid;
  logic         sum_bit;
  logic         carry_bit;
  logic         result_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         result_valid;
  logic         busy;
  logic         overrun;
  logic         parity;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  serial_result_collector #(.WIDTH(W)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .bit_valid    (bit_valid),
    .sum_bit      (sum_bit),
    .carry_bit    (carry_bit),
    .result_ready (result_ready),
    .result       (result),
    .carry_out    (carry_out),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun),
    .parity       (parity)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 waiting for start, 1 gathering bits, 2 word held for consumer.
  int           m_phase   = 0;
  bit           m_bits[$];
  logic [W-1:0] m_word    = '0;
  logic         m_carry   = 1'b0;
  logic         m_parity  = 1'b0;
  logic         m_overrun = 1'b0;

  function automatic logic exp_parity(input logic [W-1:0] w);
`ifdef SERIAL_PARITY_EN
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(w[i]);
    return logic'(ones % 2);
`else
    return 1'b0;
`endif
  endfunction

  // The model advances on each rising edge from the inputs applied since
  // the previous falling edge.
  always @(posedge clock) begin
    if (!resetn) begin
      m_phase   = 0;
      m_bits.delete();
      m_carry   = 1'b0;
      m_parity  = 1'b0;
      m_overrun = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_bits.delete();
          m_overrun = 1'b0;
        end
        1: begin
          if (start) begin
            m_bits.delete();
            m_overrun = 1'b0;
          end else if (bit_valid) begin
            m_bits.push_back(sum_bit);
            if (m_bits.size() == W) begin
              m_word = '0;
              for (int i = 0; i < W; i++) m_word = m_word | (W'(m_bits[i]) << i);
              m_carry  = carry_bit;
              m_parity = exp_parity(m_word);
              m_phase  = 2;
            end
          end
        end
        default: begin
          if (bit_valid) m_overrun = 1'b1;
          if (result_ready) m_phase = 0;
        end
      endcase
    end
  end

  // Compare process: handshake and status every cycle, and the word
  // whenever the model says a word is held.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("result_valid", 32'(result_valid), 32'(m_phase == 2));
      check("busy", 32'(busy), 32'(m_phase == 1));
      check("overrun", 32'(overrun), 32'(m_overrun));
      if (m_phase == 2) begin
        check("result", 32'(result), 32'(m_word));
        check("carry_out", 32'(carry_out), 32'(m_carry));
        check("parity", 32'(parity), 32'(m_parity));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    start = 1'b0; bit_valid = 1'b0; sum_bit = 1'b0; carry_bit = 1'b0;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sends bits [0..n-1] of word LSB first. It inserts gap idle cycles after
  // every bit except the last and puts carry_last on carry_bit with the final
  // bit of a full word.
  task automatic send_bits(input logic [W-1:0] word, input int n, input int gap,
                           input logic carry_last);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      sum_bit   = word[i];
      carry_bit = (i == W - 1) ? carry_last : 1'b0;
      step();
      bit_valid = 1'b0;
      carry_bit = 1'b0;
      if (i != n - 1)
        for (int g = 0; g < gap; g++) step();
    end
  endtask

  task automatic expect_idle_outputs_zero(input string tag);
    check({tag, "_result"}, 32'(result), 32'h0);
    check({tag, "_carry"}, 32'(carry_out), 32'h0);
    check({tag, "_valid"}, 32'(result_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_parity"}, 32'(parity), 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resetn = 1'b0;
    result_ready = 1'b0;
    idle_inputs();
    step(); step();
    expect_idle_outputs_zero("reset");
    resetn = 1'b1;
    cmp_en = 1'b1;
    step();

    // 0xA5 with carry 1 on the last bit; valid one cycle after the 8th bit.
    do_start();
    check("a5_busy", 32'(busy), 32'h1);
    send_bits(8'hA5, W, 0, 1'b1);
    check("a5_valid", 32'(result_valid), 32'h1);
    check("a5_result", 32'(result), 32'hA5);
    check("a5_model", 32'(m_word), 32'hA5);
    check("a5_carry", 32'(carry_out), 32'h1);
    check("a5_parity", 32'(parity), 32'h0);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("a5_drained", 32'(result_valid), 32'h0);
    check("a5_not_busy", 32'(busy), 32'h0);

    // 0x3C with two idle cycles between valid bits.
    do_start();
    send_bits(8'h3C, W - 1, 2, 1'b0);
    step(); step();
    check("3c_not_early", 32'(result_valid), 32'h0);
    send_bits(8'h3C >> (W - 1), 1, 0, 1'b0);
    check("3c_valid", 32'(result_valid), 32'h1);
    check("3c_result", 32'(result), 32'h3C);
    check("3c_parity", 32'(parity), 32'(exp_parity(8'h3C)));
    result_ready = 1'b1; step(); result_ready = 1'b0;

    // Three partial bits, restart, then 0x81; the partial bits must vanish.
    do_start();
    send_bits(8'hFF, 3, 0, 1'b0);
    do_start();
    send_bits(8'h81, W, 0, 1'b0);
    check("81_result", 32'(result), 32'h81);
    check("81_model", 32'(m_word), 32'h81);
    check("81_parity", 32'(parity), 32'h0);

    // Hold with ready low; bits arriving set overrun, start is ignored.
    for (int i = 0; i < 5; i++) begin
      bit_valid = (i == 2);
      sum_bit   = 1'b1;
      start     = (i == 3);
      step();
    end
    idle_inputs();
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_result", 32'(result), 32'h81);
    check("ovr_valid", 32'(result_valid), 32'h1);
    result_ready = 1'b1; step(); result_ready = 1'b0;
    check("ovr_idle", 32'(result_valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    do_start();
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Reset after four bits, then a fresh 0x0F.
    send_bits(8'hA5, 4, 0, 1'b0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    expect_idle_outputs_zero("midreset");
    bit_valid = 1'b1; step(); bit_valid = 1'b0;
    check("idle_bit_no_ovr", 32'(overrun), 32'h0);
    do_start();
    send_bits(8'h0F, W, 0, 1'b1);
    check("0f_result", 32'(result), 32'h0F);
    check("0f_parity", 32'(parity), 32'h0);
    result_ready = 1'b1; step(); result_ready = 1'b0;

    // 0x01: odd weight; parity is 1 when enabled, tied to 0 otherwise.
    do_start();
    send_bits(8'h01, W, 0, 1'b0);
    check("01_result", 32'(result), 32'h01);
`ifdef SERIAL_PARITY_EN
    check("01_parity", 32'(parity), 32'h1);
`else
    check("01_parity", 32'(parity), 32'h0);
`endif
    result_ready = 1'b1; step(); result_ready = 1'b0;

    // Random phase; the compare process checks against the model throughout.
    for (int c = 0; c < 3000; c++) begin
      resetn       = ($urandom_range(0, 199) != 0);
      start        = ($urandom_range(0, 24) == 0);
      bit_valid    = ($urandom_range(0, 1) == 1);
      sum_bit      = 1'($urandom);
      carry_bit    = 1'($urandom);
      result_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    resetn = 1'b1;
    idle_inputs();
    result_ready = 1'b0;
    step();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_result_collector
